// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM controller: command codes, FSM
// state encodings and the grant-side enumeration.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  typedef enum logic {
    GNT_SPI = 1'b0,
    GNT_LCL = 1'b1
  } side_e;

  // Commands that occupy the one-deep SPI operation slot
  function automatic logic is_queue_cmd(input logic [1:0] cmd);
    return (cmd == CMD_WR_DATA) || (cmd == CMD_RD_ADDR);
  endfunction

endpackage

// File: rtl/spi_cmd_decode.sv
// SPI word front end: rx_valid edge detect, write-address register,
// one-deep SPI operation slot and sticky overrun flag.
module spi_cmd_decode
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        spi_rx_data,
  input  logic              spi_rx_valid,
  input  logic              spi_clr,
  output logic              spi_pend,
  output logic              spi_we,
  output logic [ADDR_W-1:0] spi_addr,
  output logic [DATA_W-1:0] spi_wdata,
  output logic              tx_consume,
  output logic              err_overrun
);

  logic              rx_prev_p0;
  logic [ADDR_W-1:0] wr_addr;
  logic              word_det;
  logic              queue_det;
  logic [1:0]        cmd;
  logic [7:0]        payload;

  assign cmd       = spi_rx_data[9:8];
  assign payload   = spi_rx_data[7:0];
  assign word_det  = spi_rx_valid & ~rx_prev_p0;
  assign queue_det = word_det & is_queue_cmd(cmd);

  // Stage p0: word detect, decode and slot update in one registered step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev_p0  <= 1'b0;
      wr_addr     <= '0;
      spi_pend    <= 1'b0;
      spi_we      <= 1'b0;
      tx_consume  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      rx_prev_p0 <= spi_rx_valid;
      tx_consume <= word_det && (cmd == CMD_RD_DATA);
      if (word_det && (cmd == CMD_WR_ADDR))
        wr_addr <= payload[ADDR_W-1:0];
      if (spi_clr)
        spi_pend <= 1'b0;
      if (queue_det && spi_pend) begin
        err_overrun <= 1'b1;
      end else if (queue_det) begin
        spi_pend <= 1'b1;
        spi_we   <= (cmd == CMD_WR_DATA);
      end
    end
  end

  // Write address is frozen at queue time so a later cmd-00 cannot retarget it
  always_ff @(posedge clk) begin
    if (queue_det && !spi_pend) begin
      spi_addr  <= (cmd == CMD_WR_DATA) ? wr_addr : payload[ADDR_W-1:0];
      spi_wdata <= payload[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between the SPI command path and a local
// requester with round-robin arbitration; returns read data to each side.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              lcl_req,
  input  logic              lcl_we,
  input  logic [ADDR_W-1:0] lcl_addr,
  input  logic [DATA_W-1:0] lcl_wdata,
  output logic              lcl_gnt,
  output logic [DATA_W-1:0] lcl_rdata,
  output logic              lcl_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_overrun
);

  logic              spi_pend;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [DATA_W-1:0] spi_wdata;
  logic              tx_consume;
  logic              spi_clr;
  logic [1:0]        state;
  logic              op_we;
  side_e             grant;
  side_e             last_grant;
  side_e             pick;

  spi_cmd_decode #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_decode (
    .clk         (clk),
    .rst_n       (rst_n),
    .spi_rx_data (spi_rx_data),
    .spi_rx_valid(spi_rx_valid),
    .spi_clr     (spi_clr),
    .spi_pend    (spi_pend),
    .spi_we      (spi_we),
    .spi_addr    (spi_addr),
    .spi_wdata   (spi_wdata),
    .tx_consume  (tx_consume),
    .err_overrun (err_overrun)
  );

  // On a tie the side that was not served last wins
  function automatic side_e pick_side(input logic spi_p, input logic lcl_p,
                                      input side_e last);
    if (spi_p && lcl_p)
      return (last == GNT_LCL) ? GNT_SPI : GNT_LCL;
    return spi_p ? GNT_SPI : GNT_LCL;
  endfunction

  always_comb pick = pick_side(spi_pend, lcl_req, last_grant);

  assign ram_en  = (state == ST_ACCESS);
  assign ram_we  = ram_en & op_we;
  assign lcl_gnt = ram_en & (grant == GNT_LCL);
  assign spi_clr = ram_en & (grant == GNT_SPI);

  // Stage p1: arbitration, access and read-return capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= GNT_LCL;
      last_grant <= GNT_LCL;
      op_we      <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      lcl_rdata  <= '0;
      lcl_rvalid <= 1'b0;
    end else begin
      lcl_rvalid <= 1'b0;
      if (tx_consume)
        tx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (spi_pend || lcl_req) begin
            grant      <= pick;
            last_grant <= pick;
            op_we      <= (pick == GNT_SPI) ? spi_we    : lcl_we;
            ram_addr   <= (pick == GNT_SPI) ? spi_addr  : lcl_addr;
            ram_wdata  <= (pick == GNT_SPI) ? spi_wdata : lcl_wdata;
            state      <= ST_ACCESS;
          end
        end
        ST_ACCESS: state <= op_we ? ST_IDLE : ST_RD_WAIT;
        ST_RD_WAIT: begin
          // A return in the same cycle as a consume keeps tx_valid set
          if (grant == GNT_SPI) begin
            tx_data  <= ram_rdata;
            tx_valid <= 1'b1;
          end else begin
            lcl_rdata  <= ram_rdata;
            lcl_rvalid <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Scoreboard bench for spi_ram_arbiter: a behavioural RAM, a reference model
// of the command/arbitration rules, and a monitor checking DUT outputs.
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       lcl_req;
  logic       lcl_we;
  logic [7:0] lcl_addr;
  logic [7:0] lcl_wdata;
  logic       lcl_gnt;
  logic [7:0] lcl_rdata;
  logic       lcl_rvalid;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       err_overrun;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .lcl_req(lcl_req), .lcl_we(lcl_we), .lcl_addr(lcl_addr), .lcl_wdata(lcl_wdata),
    .lcl_gnt(lcl_gnt), .lcl_rdata(lcl_rdata), .lcl_rvalid(lcl_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  // Behavioural single-port RAM with one cycle of read latency
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
  always @(posedge clk) begin
    if (ram_en && ram_we)  mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  typedef struct packed { logic lcl; logic we; logic [7:0] addr; logic [7:0] data; int t; } acc_t;
  typedef struct packed { logic v; logic [7:0] d; int t; } tx_t;
  typedef struct packed { logic [7:0] d; int t; } lrd_t;

  acc_t acc_q[$];
  tx_t  tx_q[$];
  lrd_t lrd_q[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  logic [7:0] ref_mem [256];
  logic [7:0] ref_wr_addr;
  logic       ref_txv;
  logic [7:0] ref_txd;
  logic       ref_ovr;
  logic       last_side;   // 1 = local served last
  logic       lcl_free;    // held-request phase: local traffic not scored

  task automatic model_reset();
    ref_wr_addr = 8'h00;
    ref_txv     = 1'b0;
    ref_txd     = 8'h00;
    ref_ovr     = 1'b0;
    last_side   = 1'b1;
  endtask

  task automatic push_acc(input logic l, input logic we, input logic [7:0] a,
                          input logic [7:0] d, input int t);
    acc_t e;
    e.lcl = l; e.we = we; e.addr = a; e.data = d; e.t = t;
    acc_q.push_back(e);
  endtask

  task automatic push_tx(input logic v, input logic [7:0] d, input int t);
    tx_t e;
    e.v = v; e.d = d; e.t = t;
    tx_q.push_back(e);
  endtask

  // mode: 0 timed, 1 untimed, 2 dropped by overrun, 3 read aborted by reset,
  // 4 consume colliding with a read return
  task automatic model_spi(input logic [9:0] w, input int t, input int mode);
    logic [7:0] p;
    int         te;
    lrd_t       unused_l;
    p  = w[7:0];
    te = (mode == 1) ? -1 : t + 2;
    unused_l = '0;
    case (w[9:8])
      2'b00: ref_wr_addr = p;
      2'b01: begin
        if (mode == 2) ref_ovr = 1'b1;
        else begin
          push_acc(1'b0, 1'b1, ref_wr_addr, p, te);
          ref_mem[ref_wr_addr] = p;
          last_side = 1'b0;
        end
      end
      2'b10: begin
        if (mode == 2) ref_ovr = 1'b1;
        else begin
          push_acc(1'b0, 1'b0, p, 8'h00, te);
          if (mode != 3) begin
            ref_txv = 1'b1;
            ref_txd = ref_mem[p];
            push_tx(1'b1, ref_txd, t + 4);
          end
          last_side = 1'b0;
        end
      end
      default: begin
        if (mode != 4) begin
          ref_txv = 1'b0;
          push_tx(1'b0, 8'h00, t + 2);
        end
      end
    endcase
  endtask

  task automatic model_lcl(input logic we, input logic [7:0] a, input logic [7:0] d, input int k);
    lrd_t e;
    push_acc(1'b1, we, a, d, (k < 0) ? -1 : k + 1);
    if (we) ref_mem[a] = d;
    else begin
      e.d = ref_mem[a];
      e.t = (k < 0) ? -1 : k + 3;
      lrd_q.push_back(e);
      if (k >= 0) push_tx(ref_txv, ref_txd, k + 3);
    end
    last_side = 1'b1;
  endtask

  task automatic spi_send(input logic [9:0] w, input int hold, input int mode);
    @(negedge clk);
    spi_rx_data  = w;
    spi_rx_valid = 1'b1;
    model_spi(w, cyc, mode);
    repeat (hold) @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  task automatic lcl_op(input logic we, input logic [7:0] a, input logic [7:0] d,
                        input logic push, input logic timed);
    logic got;
    @(negedge clk);
    lcl_req = 1'b1; lcl_we = we; lcl_addr = a; lcl_wdata = d;
    if (push) model_lcl(we, a, d, timed ? cyc : -1);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (lcl_gnt) begin got = 1'b1; break; end
    end
    lcl_req = 1'b0;
    if (!got) check("lcl_gnt_timeout", got, 1);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI word and local write pending in the same IDLE cycle
  task automatic tie(input logic [9:0] w, input logic [7:0] a, input logic [7:0] d);
    logic win_lcl;
    win_lcl = (last_side == 1'b0);
    if (win_lcl) model_lcl(1'b1, a, d, -1);
    fork
      spi_send(w, 3, 1);
      begin
        @(negedge clk);
        lcl_op(1'b1, a, d, !win_lcl, 1'b0);
      end
    join
    last_side = win_lcl ? 1'b0 : 1'b1;
  endtask

  acc_t m_acc;
  tx_t  m_tx;
  lrd_t m_lrd;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_en && !(lcl_free && lcl_gnt)) begin
        if (acc_q.size() == 0) check("ram_en_unexpected", ram_en, 0);
        else begin
          m_acc = acc_q.pop_front();
          check("acc_side", lcl_gnt, m_acc.lcl);
          check("acc_we", ram_we, m_acc.we);
          check("acc_addr", ram_addr, m_acc.addr);
          if (m_acc.we) check("acc_wdata", ram_wdata, m_acc.data);
          if (m_acc.t >= 0) check("acc_cycle", cyc, m_acc.t);
        end
      end
      if (lcl_rvalid && !lcl_free) begin
        if (lrd_q.size() == 0) check("lcl_rvalid_unexpected", lcl_rvalid, 0);
        else begin
          m_lrd = lrd_q.pop_front();
          check("lcl_rdata", lcl_rdata, m_lrd.d);
          if (m_lrd.t >= 0) check("lcl_rvalid_cycle", cyc, m_lrd.t);
        end
      end
      while (tx_q.size() > 0 && tx_q[0].t < cyc) begin
        m_tx = tx_q.pop_front();
        check("tx_missed", cyc, m_tx.t);
      end
      if (tx_q.size() > 0 && tx_q[0].t == cyc) begin
        m_tx = tx_q.pop_front();
        check("tx_valid", tx_valid, m_tx.v);
        if (m_tx.v) check("tx_data", tx_data, m_tx.d);
      end
    end
  end

  logic [7:0] ra, rd;
  int         op;

  initial begin
    rst_n = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = '0;
    lcl_req = 1'b0; lcl_we = 1'b0; lcl_addr = '0; lcl_wdata = '0; lcl_free = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    model_reset();
    gap(3);
    check("reset_outputs", {tx_data, tx_valid, lcl_gnt, lcl_rdata, lcl_rvalid, ram_en,
                            ram_we, ram_addr, ram_wdata, err_overrun}, 0);
    rst_n = 1'b1;
    gap(3);

    // First tie after reset: SPI wins, local follows
    tie(10'h1AB, 8'h10, 8'h55);
    gap(12);

    // Address set, write, read-back, consume
    spi_send(10'h0A5, 3, 0); gap(10);
    spi_send(10'h13C, 3, 0); gap(10);
    spi_send(10'h2A5, 3, 0); gap(10);
    spi_send(10'h300, 3, 0); gap(10);
    check("err_overrun_clear", err_overrun, ref_ovr);

    // Second tie with SPI served last: local wins
    tie(10'h1C7, 8'h11, 8'h66);
    gap(12);

    lcl_op(1'b0, 8'h10, 8'h00, 1'b1, 1'b1); gap(10);

    // Read return coinciding with a consume word
    spi_send(10'h210, 1, 0);
    spi_send(10'h300, 1, 4);
    push_tx(ref_txv, ref_txd, cyc + 2);
    gap(12);

    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 5);
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      case (op)
        0: spi_send({2'b00, ra}, 3, 0);
        1: spi_send({2'b01, rd}, 3, 0);
        2: spi_send({2'b10, ra}, 3, 0);
        3: spi_send({2'b11, rd}, 3, 0);
        4: lcl_op(1'b1, ra, rd, 1'b1, 1'b1);
        default: lcl_op(1'b0, ra, rd, 1'b1, 1'b1);
      endcase
      gap(12);
    end

    // Continuous local requests while two SPI words arrive 2 cycles apart
    @(negedge clk);
    lcl_free = 1'b1; lcl_we = 1'b0; lcl_addr = 8'h77; lcl_req = 1'b1;
    spi_send(10'h1E1, 1, 1);
    spi_send(10'h1E2, 1, 2);
    gap(12);
    lcl_req = 1'b0;
    gap(8);
    lcl_free = 1'b0;
    check("err_overrun_set", err_overrun, ref_ovr);
    spi_send(10'h05A, 3, 0); gap(10);
    check("err_overrun_sticky", err_overrun, ref_ovr);

    // Reset while the read is in RD_WAIT
    spi_send(10'h2A5, 1, 3);
    gap(2);
    rst_n = 1'b0;
    gap(1);
    check("reset_mid_read", {tx_data, tx_valid, lcl_gnt, lcl_rdata, lcl_rvalid, ram_en,
                             ram_we, ram_addr, ram_wdata, err_overrun}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 5; i++) push_tx(1'b0, 8'h00, cyc + i);
    gap(6);
    spi_send(10'h1C3, 3, 0);
    gap(20);

    check("acc_q_drained", acc_q.size(), 0);
    check("lrd_q_drained", lrd_q.size(), 0);
    check("tx_q_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
